ibex_wb_buffer: RTL and testbench

IBEX_WB_BUFFER -- requirements
Module: ibex_wb_buffer

---
 rtl/ibex_wb_buffer.sv | 122 ++++++++++++
 tb/tb_ibex_wb_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_buffer.sv
// Writeback buffer: in-order queue of pending register-file writes with
// youngest-match operand forwarding. x0 writes are accepted and dropped.
module ibex_wb_buffer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [4:0]                   in_waddr_i,
  input  logic [DataWidth-1:0]         in_wdata_i,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_waddr_o,
  output logic [DataWidth-1:0]         rf_wdata_o,
  input  logic                         rf_gnt_i,
  input  logic [4:0]                   raddr_a_i,
  input  logic [4:0]                   raddr_b_i,
  output logic                         fwd_hit_a_o,
  output logic                         fwd_hit_b_o,
  output logic [DataWidth-1:0]         fwd_data_a_o,
  output logic [DataWidth-1:0]         fwd_data_b_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [4:0]           waddr_q [Depth];
  logic [4:0]           waddr_d [Depth];
  logic [DataWidth-1:0] wdata_q [Depth];
  logic [DataWidth-1:0] wdata_d [Depth];

  logic push, alloc, pop;
  logic [PtrW:0]   age_sum;
  logic [PtrW-1:0] age_idx;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    ptr_inc = (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake and status depend only on registered occupancy
  assign in_ready_o = (count_q < CntW'(Depth));
  assign rf_we_o    = (count_q != '0);
  assign rf_waddr_o = rf_we_o ? waddr_q[rd_ptr_q] : 5'd0;
  assign rf_wdata_o = rf_we_o ? wdata_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  assign push  = in_valid_i && in_ready_o;
  assign alloc = push && (in_waddr_i != 5'd0);
  assign pop   = rf_we_o && rf_gnt_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (alloc) begin
      waddr_d[wr_ptr_q] = in_waddr_i;
      wdata_d[wr_ptr_q] = in_wdata_i;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({alloc, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk entries oldest to youngest so the last match wins
  always_comb begin
    fwd_hit_a_o  = 1'b0;
    fwd_hit_b_o  = 1'b0;
    fwd_data_a_o = '0;
    fwd_data_b_o = '0;
    age_sum      = '0;
    age_idx      = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      age_sum = {1'b0, rd_ptr_q} + (PtrW + 1)'(i);
      if (age_sum >= (PtrW + 1)'(Depth)) begin
        age_sum = age_sum - (PtrW + 1)'(Depth);
      end
      age_idx = age_sum[PtrW-1:0];
      if (CntW'(i) < count_q) begin
        if ((raddr_a_i != 5'd0) && (waddr_q[age_idx] == raddr_a_i)) begin
          fwd_hit_a_o  = 1'b1;
          fwd_data_a_o = wdata_q[age_idx];
        end
        if ((raddr_b_i != 5'd0) && (waddr_q[age_idx] == raddr_b_i)) begin
          fwd_hit_b_o  = 1'b1;
          fwd_data_b_o = wdata_q[age_idx];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload is never exposed while unoccupied, so it needs no reset
  always_ff @(posedge clk_i) begin
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_ibex_wb_buffer.sv
// Directed testbench for ibex_wb_buffer (DataWidth=32, Depth=2).
module tb_ibex_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  in_waddr_i;
  logic [31:0] in_wdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_gnt_i;
  logic [4:0]  raddr_a_i;
  logic [4:0]  raddr_b_i;
  logic        fwd_hit_a_o;
  logic        fwd_hit_b_o;
  logic [31:0] fwd_data_a_o;
  logic [31:0] fwd_data_b_o;
  logic [1:0]  count_o;

  int checks   = 0;
  int failures = 0;

  ibex_wb_buffer #(.DataWidth(32), .Depth(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_waddr_i   (in_waddr_i),
    .in_wdata_i   (in_wdata_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .rf_gnt_i     (rf_gnt_i),
    .raddr_a_i    (raddr_a_i),
    .raddr_b_i    (raddr_b_i),
    .fwd_hit_a_o  (fwd_hit_a_o),
    .fwd_hit_b_o  (fwd_hit_b_o),
    .fwd_data_a_o (fwd_data_a_o),
    .fwd_data_b_o (fwd_data_b_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    raddr_a_i = 5'd5;
    raddr_b_i = 5'd0;
    tick();
    rst_i = 1'b0;
    checks++; if (count_o !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0) begin failures++; $display("FAIL reset_rf got=%0d/%h exp=0/0", rf_waddr_o, rf_wdata_o); end
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", in_ready_o); end
    checks++; if (fwd_hit_a_o !== 1'b0 || fwd_data_a_o !== 32'd0) begin failures++; $display("FAIL reset_fwd_a got=%0b/%h exp=0/0", fwd_hit_a_o, fwd_data_a_o); end
    checks++; if (fwd_hit_b_o !== 1'b0 || fwd_data_b_o !== 32'd0) begin failures++; $display("FAIL reset_fwd_b got=%0b/%h exp=0/0", fwd_hit_b_o, fwd_data_b_o); end
  endtask

  task automatic test_basic();
    rf_gnt_i = 1'b1;
    in_valid_i = 1'b1; in_waddr_i = 5'd5; in_wdata_i = 32'hDEADBEEF;
    checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL basic_no_comb_path got=%0b exp=0", rf_we_o); end
    tick();
    in_valid_i = 1'b0;
    checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL basic_write got=%0b/%0d/%h exp=1/5/deadbeef", rf_we_o, rf_waddr_o, rf_wdata_o); end
    checks++; if (count_o !== 2'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count_o); end
    tick();
    checks++; if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || count_o !== 2'd0) begin
      failures++; $display("FAIL basic_drain got=%0b/%0d/%0d exp=0/0/0", rf_we_o, rf_waddr_o, count_o); end
  endtask

  task automatic test_fill_stall();
    rf_gnt_i = 1'b0;
    in_valid_i = 1'b1; in_waddr_i = 5'd1; in_wdata_i = 32'h11;
    tick();
    in_waddr_i = 5'd2; in_wdata_i = 32'h22;
    tick();
    in_waddr_i = 5'd3; in_wdata_i = 32'h33;
    checks++; if (count_o !== 2'd2 || in_ready_o !== 1'b0) begin failures++; $display("FAIL fill_full got=%0d/%0b exp=2/0", count_o, in_ready_o); end
    checks++; if (rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'h11) begin failures++; $display("FAIL fill_head got=%0d/%h exp=1/11", rf_waddr_o, rf_wdata_o); end
    tick();
    in_valid_i = 1'b0;
    checks++; if (count_o !== 2'd2 || rf_we_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'h11) begin
      failures++; $display("FAIL stall_hold got=%0d/%0b/%0d/%h exp=2/1/1/11", count_o, rf_we_o, rf_waddr_o, rf_wdata_o); end
    rf_gnt_i = 1'b1;
    #1;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL ready_no_comb_gnt got=%0b exp=0", in_ready_o); end
    tick();
    checks++; if (rf_waddr_o !== 5'd2 || rf_wdata_o !== 32'h22 || in_ready_o !== 1'b1 || count_o !== 2'd1) begin
      failures++; $display("FAIL fill_second got=%0d/%h/%0b/%0d exp=2/22/1/1", rf_waddr_o, rf_wdata_o, in_ready_o, count_o); end
    tick();
    checks++; if (rf_we_o !== 1'b0 || count_o !== 2'd0) begin failures++; $display("FAIL fill_empty got=%0b/%0d exp=0/0", rf_we_o, count_o); end
    rf_gnt_i = 1'b0;
  endtask

  task automatic test_forward();
    rf_gnt_i = 1'b0;
    raddr_a_i = 5'd7; raddr_b_i = 5'd0;
    in_valid_i = 1'b1; in_waddr_i = 5'd7; in_wdata_i = 32'hA;
    #1;
    checks++; if (fwd_hit_a_o !== 1'b0) begin failures++; $display("FAIL fwd_no_same_cycle got=%0b exp=0", fwd_hit_a_o); end
    tick();
    in_wdata_i = 32'hB;
    checks++; if (fwd_hit_a_o !== 1'b1 || fwd_data_a_o !== 32'hA) begin failures++; $display("FAIL fwd_single got=%0b/%h exp=1/a", fwd_hit_a_o, fwd_data_a_o); end
    tick();
    in_valid_i = 1'b0;
    checks++; if (fwd_hit_a_o !== 1'b1 || fwd_data_a_o !== 32'hB) begin failures++; $display("FAIL fwd_youngest got=%0b/%h exp=1/b", fwd_hit_a_o, fwd_data_a_o); end
    checks++; if (fwd_hit_b_o !== 1'b0 || fwd_data_b_o !== 32'd0) begin failures++; $display("FAIL fwd_x0 got=%0b/%h exp=0/0", fwd_hit_b_o, fwd_data_b_o); end
    raddr_b_i = 5'd8;
    #1;
    checks++; if (fwd_hit_b_o !== 1'b0 || fwd_data_b_o !== 32'd0) begin failures++; $display("FAIL fwd_miss got=%0b/%h exp=0/0", fwd_hit_b_o, fwd_data_b_o); end
    rf_gnt_i = 1'b1;
    #1;
    checks++; if (fwd_hit_a_o !== 1'b1 || fwd_data_a_o !== 32'hB) begin failures++; $display("FAIL fwd_popping got=%0b/%h exp=1/b", fwd_hit_a_o, fwd_data_a_o); end
    tick();
    checks++; if (fwd_hit_a_o !== 1'b1 || fwd_data_a_o !== 32'hB) begin failures++; $display("FAIL fwd_after_pop got=%0b/%h exp=1/b", fwd_hit_a_o, fwd_data_a_o); end
    tick();
    checks++; if (fwd_hit_a_o !== 1'b0 || fwd_data_a_o !== 32'd0) begin failures++; $display("FAIL fwd_gone got=%0b/%h exp=0/0", fwd_hit_a_o, fwd_data_a_o); end
    rf_gnt_i = 1'b0;
    raddr_a_i = 5'd0; raddr_b_i = 5'd0;
  endtask

  task automatic test_x0_drop();
    rf_gnt_i = 1'b0;
    in_valid_i = 1'b1; in_waddr_i = 5'd0; in_wdata_i = 32'hFFFFFFFF;
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL x0_ready got=%0b exp=1", in_ready_o); end
    tick();
    in_valid_i = 1'b0;
    checks++; if (count_o !== 2'd0 || rf_we_o !== 1'b0 || rf_wdata_o !== 32'd0) begin
      failures++; $display("FAIL x0_drop got=%0d/%0b/%h exp=0/0/0", count_o, rf_we_o, rf_wdata_o); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    rf_gnt_i = 1'b1;
    in_valid_i = 1'b1; in_waddr_i = 5'd10; in_wdata_i = 32'h100;
    tick();
    exp_addr = 5'd10; exp_data = 32'h100;
    for (int i = 0; i < 10; i++) begin
      in_waddr_i = 5'(11 + i); in_wdata_i = 32'h200 + 32'(i);
      checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== exp_addr || rf_wdata_o !== exp_data) begin
        failures++; $display("FAIL b2b_order[%0d] got=%0d/%h exp=%0d/%h", i, rf_waddr_o, rf_wdata_o, exp_addr, exp_data); end
      tick();
      checks++; if (count_o !== 2'd1) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=1", i, count_o); end
      exp_addr = 5'(11 + i); exp_data = 32'h200 + 32'(i);
    end
    in_valid_i = 1'b0;
    checks++; if (rf_waddr_o !== 5'd20 || rf_wdata_o !== 32'h209) begin failures++; $display("FAIL b2b_last got=%0d/%h exp=20/209", rf_waddr_o, rf_wdata_o); end
    tick();
    checks++; if (count_o !== 2'd0 || rf_we_o !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0d/%0b exp=0/0", count_o, rf_we_o); end
    rf_gnt_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    rf_gnt_i = 1'b0;
    in_valid_i = 1'b1; in_waddr_i = 5'd3; in_wdata_i = 32'h33;
    tick();
    in_waddr_i = 5'd4; in_wdata_i = 32'h44;
    tick();
    checks++; if (count_o !== 2'd2) begin failures++; $display("FAIL rstmid_full got=%0d exp=2", count_o); end
    rst_i = 1'b1; rf_gnt_i = 1'b1; in_waddr_i = 5'd6; in_wdata_i = 32'h66;
    raddr_a_i = 5'd3;
    tick();
    rst_i = 1'b0; in_valid_i = 1'b0;
    checks++; if (count_o !== 2'd0 || rf_we_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++; $display("FAIL rstmid_state got=%0d/%0b/%0b exp=0/0/1", count_o, rf_we_o, in_ready_o); end
    checks++; if (rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0 || fwd_hit_a_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%0d/%h/%0b exp=0/0/0", rf_waddr_o, rf_wdata_o, fwd_hit_a_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_we_o !== 1'b0) begin failures++; $display("FAIL rstmid_leak[%0d] got=%0b exp=0", i, rf_we_o); end
    end
    rf_gnt_i = 1'b0; raddr_a_i = 5'd0;
  endtask

  initial begin
    rst_i = 1'b1;
    in_valid_i = 1'b0; in_waddr_i = 5'd0; in_wdata_i = 32'd0;
    rf_gnt_i = 1'b0; raddr_a_i = 5'd0; raddr_b_i = 5'd0;
    test_reset();
    test_basic();
    test_fill_stall();
    test_forward();
    test_x0_drop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
